// File: rtl/decoder_rr_arbiter_pkg.sv
// rtl/decoder_rr_arbiter_pkg.sv - shared constants, FSM encoding and grant decode for the round-robin decoder arbiter
package decoder_rr_arbiter_pkg;

    localparam int N_REQ            = 8;
    localparam int IDX_W            = 3;
    localparam int MAX_HOLD_DEFAULT = 15;
    localparam int HOLD_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // 3-to-8 decode of the owner index, forced to zero when the enable is low
    function automatic logic [N_REQ-1:0] idx_decode(input logic en, input logic [IDX_W-1:0] idx);
        idx_decode = en ? (N_REQ'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// rtl/decoder_rr_arbiter_if.sv - request/grant bus between requesters and the decoder arbiter
interface decoder_rr_arbiter_if;
    import decoder_rr_arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic             e;
    logic             a;
    logic             b;
    logic             c;
    logic [N_REQ-1:0] grant;
    logic             timeout;

    modport master (output req, output done,
                    input e, input a, input b, input c, input grant, input timeout);
    modport slave  (input req, input done,
                    output e, output a, output b, output c, output grant, output timeout);
endinterface

// File: rtl/decoder_rr_arbiter_rr_priority_pick.sv
// rtl/decoder_rr_arbiter_rr_priority_pick.sv - first set request bit at or above a start index, wrapping
module rr_priority_pick
    import decoder_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = start;
        cand  = start;
        for (int i = 0; i < N_REQ; i++) begin
            cand = start + IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin owner select with hold limit, dead cycle between owners and decoded grant
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    decoder_rr_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;

    rr_priority_pick u_pick (
        .req   (bus.req),
        .start (last_q + IDX_W'(1)),
        .found (pick_found),
        .index (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                hold_d = hold_q + HOLD_W'(1);
                // A voluntary release on the expiry cycle is not a timeout
                if (bus.done || !bus.req[owner_q]) begin
                    state_d = ST_GAP;
                    hold_d  = '0;
                end else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = ST_GAP;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.e       = (state_q == ST_GRANT);
    assign bus.a       = owner_q[2];
    assign bus.b       = owner_q[1];
    assign bus.c       = owner_q[0];
    assign bus.grant   = idx_decode(state_q == ST_GRANT, owner_q);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - directed vector table plus multi-cycle sequences for decoder_rr_arbiter
module tb_decoder_rr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   mon_en;

    decoder_rr_arbiter_if bus ();

    decoder_rr_arbiter #(.MAX_HOLD(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic       e;
        logic [7:0] grant;
        logic [2:0] abc;
        logic       to;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] r);
        rst      = 1'b1;
        bus.req  = r;
        bus.done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Structural invariants checked on every falling edge once outputs are defined
    always @(negedge clk) begin
        if (mon_en) begin
            logic [7:0] exp_g;
            exp_g = 8'd1 << {bus.a, bus.b, bus.c};
            checks++;
            if ($countones(bus.grant) > 1 || ((bus.grant != 8'd0) != bus.e) ||
                (bus.e && bus.grant != exp_g)) begin
                errors++;
                $display("FAIL invariant @%0t: grant=%0h e=%0b abc=%0d", $time, bus.grant, bus.e,
                         {bus.a, bus.b, bus.c});
            end
        end
    end

    initial begin
        int n;
        int gap;
        int ecnt;
        logic to_seen_early;
        logic to_at_fall;
        logic [7:0] exp_g;

        checks   = 0;
        errors   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;

        //          rst  req    done  e     grant  abc   to
        vt[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vt[1]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        vt[2]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0};
        vt[3]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        vt[4]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vt[5]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0};
        vt[6]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[7]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0};
        vt[8]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0};
        vt[9]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0};
        vt[10] = '{1'b0, 8'hFB, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0};
        vt[11] = '{1'b0, 8'hFB, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0};
        vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0};
        vt[14] = '{1'b0, 8'h09, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0};
        vt[15] = '{1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0};
        vt[16] = '{1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0};
        vt[17] = '{1'b0, 8'h01, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0};
        vt[18] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vt[19] = '{1'b0, 8'h80, 1'b0, 1'b1, 8'h80, 3'd7, 1'b0};

        for (int i = 0; i < 20; i++) begin
            rst      = vt[i].rst;
            bus.req  = vt[i].req;
            bus.done = vt[i].done;
            step();
            mon_en = 1'b1;
            chk($sformatf("vec%0d_e", i), 32'(bus.e), 32'(vt[i].e));
            chk($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vt[i].grant));
            chk($sformatf("vec%0d_abc", i), 32'({bus.a, bus.b, bus.c}), 32'(vt[i].abc));
            chk($sformatf("vec%0d_timeout", i), 32'(bus.timeout), 32'(vt[i].to));
        end

        // Rotation with all requesting and a one-cycle grant each time
        do_reset(8'hFF);
        step();
        chk("rot_first_latency_e", 32'(bus.e), 32'd1);
        for (int k = 0; k < 9; k++) begin
            n = 0;
            while (!bus.e && n < 6) begin
                step();
                n++;
            end
            exp_g = 8'd1 << (k % 8);
            chk($sformatf("rot%0d_grant", k), 32'(bus.grant), 32'(exp_g));
            chk($sformatf("rot%0d_abc", k), 32'({bus.a, bus.b, bus.c}), 32'(k % 8));
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            chk($sformatf("rot%0d_released", k), 32'(bus.e), 32'd0);
            gap = 0;
            while (!bus.e && gap < 6) begin
                step();
                gap++;
            end
            chk($sformatf("rot%0d_regrant_in_budget", k), 32'(bus.e), 32'd1);
        end

        // Hold limit expiry on a single persistent requester
        do_reset(8'h10);
        step();
        chk("hold_first_grant", 32'(bus.grant), 32'h10);
        ecnt          = 1;
        to_seen_early = 1'b0;
        to_at_fall    = 1'b0;
        n             = 0;
        while (bus.e && n < 40) begin
            if (bus.timeout) to_seen_early = 1'b1;
            step();
            n++;
            if (bus.e) ecnt++;
            else to_at_fall = bus.timeout;
        end
        chk("hold_e_cycles", 32'(ecnt), 32'd15);
        chk("hold_timeout_at_fall", 32'(to_at_fall), 32'd1);
        chk("hold_no_early_timeout", 32'(to_seen_early), 32'd0);
        step();
        chk("hold_timeout_one_cycle", 32'(bus.timeout), 32'd0);
        chk("hold_idle_e", 32'(bus.e), 32'd0);
        step();
        chk("hold_regrant", 32'(bus.grant), 32'h10);

        // Owner drops its request mid-grant; search resumes above it
        do_reset(8'h08);
        step();
        chk("drop_owner3", 32'(bus.grant), 32'h08);
        step();
        bus.req = 8'h81;
        step();
        chk("drop_e_falls", 32'(bus.e), 32'd0);
        chk("drop_no_timeout", 32'(bus.timeout), 32'd0);
        step();
        step();
        chk("drop_next_grant", 32'(bus.grant), 32'h80);

        // Reset in the middle of a grant
        do_reset(8'h20);
        step();
        chk("rst_owner5", 32'(bus.grant), 32'h20);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_mid_e", 32'(bus.e), 32'd0);
        chk("rst_mid_grant", 32'(bus.grant), 32'd0);
        chk("rst_mid_timeout", 32'(bus.timeout), 32'd0);
        rst     = 1'b0;
        bus.req = 8'h20;
        step();
        chk("rst_regrant", 32'(bus.grant), 32'h20);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
